// File: rtl/drca_arbiter_if.sv
// Handshake and adder-side bundle between the requesters, the DRCA arbiter and the adder.
// slave = arbiter side, master = the surrounding sources, sink and adder.
interface drca_arbiter_if #(
    parameter int N = 16
);
    logic         req0_valid;
    logic         req0_ready;
    logic [N-1:0] req0_a;
    logic [N-1:0] req0_b;
    logic         req0_cin;

    logic         req1_valid;
    logic         req1_ready;
    logic [N-1:0] req1_a;
    logic [N-1:0] req1_b;
    logic         req1_cin;

    logic         adder_en;
    logic [N-1:0] adder_a;
    logic [N-1:0] adder_b;
    logic         adder_cin;
    logic [N-1:0] adder_s;
    logic         adder_cout;

    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [N:0]   rsp_sum;

    logic [31:0]  perf_ops;
    logic [31:0]  perf_busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_cin,
        output req1_ready,
        output adder_en, adder_a, adder_b, adder_cin,
        input  adder_s, adder_cout,
        output rsp_valid, rsp_id, rsp_sum,
        input  rsp_ready,
        output perf_ops, perf_busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_cin,
        input  req1_ready,
        input  adder_en, adder_a, adder_b, adder_cin,
        output adder_s, adder_cout,
        input  rsp_valid, rsp_id, rsp_sum,
        output rsp_ready,
        input  perf_ops, perf_busy
    );
endinterface

// File: rtl/drca_arbiter.sv
// Round-robin sequencer sharing one dynamic ripple-carry adder between two requesters.
// Optional performance counters are built only when DRCA_ARB_PERF_EN is defined.
module drca_arbiter #(
    parameter int N          = 16,
    parameter int GD_PER_CYC = 4
) (
    input  logic          clk,
    input  logic          rst,
    drca_arbiter_if.slave bus
);
    localparam int CW = $clog2(N / GD_PER_CYC + 2);
    localparam int LW = $clog2(N + 1);

    // state  | meaning
    // S_IDLE | waiting for a request; ready goes to the granted requester
    // S_WAIT | adder enabled, operands held, settle counter running
    // S_RESP | captured sum presented until the consumer takes it
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        state_q;
    logic          rr_q;
    logic [CW-1:0] cnt_q;
    logic          adder_en_q;
    logic [N-1:0]  adder_a_q;
    logic [N-1:0]  adder_b_q;
    logic          adder_cin_q;
    logic          rsp_valid_q;
    logic          rsp_id_q;
    logic [N:0]    rsp_sum_q;

    logic          idle_d;
    logic          grant0_d;
    logic          grant1_d;
    logic          hs_d;
    logic [N-1:0]  sel_a_d;
    logic [N-1:0]  sel_b_d;
    logic          sel_cin_d;
    logic [LW-1:0] run_d;
    logic [CW-1:0] wait_d;

    // Longest run of propagate bits bounds how far a carry can ripple.
    function automatic logic [LW-1:0] longest_run(input logic [N-1:0] p);
        logic [LW-1:0] run;
        logic [LW-1:0] best;
        run  = '0;
        best = '0;
        for (int i = 0; i < N; i++) begin
            if (p[i]) run = run + 1'b1;
            else      run = '0;
            if (run > best) best = run;
        end
        return best;
    endfunction

    assign idle_d    = !rst && (state_q == S_IDLE);
    assign grant0_d  = bus.req0_valid && (!rr_q || !bus.req1_valid);
    assign grant1_d  = bus.req1_valid && (rr_q || !bus.req0_valid);
    assign hs_d      = idle_d && (grant0_d || grant1_d);

    assign sel_a_d   = grant1_d ? bus.req1_a   : bus.req0_a;
    assign sel_b_d   = grant1_d ? bus.req1_b   : bus.req0_b;
    assign sel_cin_d = grant1_d ? bus.req1_cin : bus.req0_cin;
    assign run_d     = longest_run(sel_a_d ^ sel_b_d);
    assign wait_d    = CW'(int'(run_d) / GD_PER_CYC + 1);

    assign bus.req0_ready = idle_d && grant0_d;
    assign bus.req1_ready = idle_d && grant1_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_q        <= 1'b0;
            cnt_q       <= '0;
            adder_en_q  <= 1'b0;
            adder_a_q   <= '0;
            adder_b_q   <= '0;
            adder_cin_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_sum_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (hs_d) begin
                        adder_a_q   <= sel_a_d;
                        adder_b_q   <= sel_b_d;
                        adder_cin_q <= sel_cin_d;
                        rsp_id_q    <= grant1_d;
                        cnt_q       <= wait_d;
                        adder_en_q  <= 1'b1;
                        state_q     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        rsp_sum_q   <= {bus.adder_cout, bus.adder_s};
                        adder_en_q  <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rr_q        <= ~rsp_id_q;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.adder_en  = adder_en_q;
    assign bus.adder_a   = adder_a_q;
    assign bus.adder_b   = adder_b_q;
    assign bus.adder_cin = adder_cin_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = rsp_sum_q;

`ifdef DRCA_ARB_PERF_EN
    logic [31:0] perf_ops_q;
    logic [31:0] perf_busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_ops_q  <= '0;
            perf_busy_q <= '0;
        end else begin
            if (state_q != S_IDLE)
                perf_busy_q <= perf_busy_q + 32'd1;
            if (state_q == S_RESP && bus.rsp_ready)
                perf_ops_q <= perf_ops_q + 32'd1;
        end
    end

    assign bus.perf_ops  = perf_ops_q;
    assign bus.perf_busy = perf_busy_q;
`else
    assign bus.perf_ops  = '0;
    assign bus.perf_busy = '0;
`endif
endmodule

// File: tb/tb_drca_arbiter.sv
// Bench for drca_arbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed sums, latencies and arbitration order.
module tb_drca_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_err    = 0;

    drca_arbiter_if #(.N(16)) bus ();

    drca_arbiter #(.N(16), .GD_PER_CYC(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural DRCA: settled sum only while enabled
    assign {bus.adder_cout, bus.adder_s} = bus.adder_en
        ? (17'(bus.adder_a) + 17'(bus.adder_b) + 17'(bus.adder_cin)) : 17'h0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            if (n_err < 40)
                $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: transaction bookkeeping, not a state machine copy
    int          m_en_left = 0;
    logic        m_rsp = 1'b0;
    logic        m_rr = 1'b0;
    logic        m_id = 1'b0;
    logic [15:0] m_a = '0;
    logic [15:0] m_b = '0;
    logic        m_cin = 1'b0;
    logic [16:0] m_sum = '0;
    logic [16:0] m_sum_out = '0;
    logic [31:0] m_ops = '0;
    logic [31:0] m_busy = '0;

    function automatic int run_len(input logic [15:0] p);
        logic [15:0] x;
        int l;
        x = p;
        l = 0;
        while (x != 16'h0) begin
            x = x & (x >> 1);
            l++;
        end
        return l;
    endfunction

    function automatic int pick();
        if (bus.req0_valid && bus.req1_valid) return m_rr ? 1 : 0;
        if (bus.req0_valid) return 0;
        if (bus.req1_valid) return 1;
        return -1;
    endfunction

    function automatic logic m_idle();
        return (m_en_left == 0) && !m_rsp;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_en_left <= 0;
            m_rsp     <= 1'b0;
            m_rr      <= 1'b0;
            m_id      <= 1'b0;
            m_a       <= '0;
            m_b       <= '0;
            m_cin     <= 1'b0;
            m_sum     <= '0;
            m_sum_out <= '0;
            m_ops     <= '0;
            m_busy    <= '0;
        end else if (m_rsp) begin
            m_busy <= m_busy + 1;
            if (bus.rsp_ready) begin
                m_rsp <= 1'b0;
                m_rr  <= ~m_id;
                m_ops <= m_ops + 1;
            end
        end else if (m_en_left != 0) begin
            m_busy    <= m_busy + 1;
            m_en_left <= m_en_left - 1;
            if (m_en_left == 1) begin
                m_rsp     <= 1'b1;
                m_sum_out <= m_sum;
            end
        end else if (pick() == 0) begin
            m_id      <= 1'b0;
            m_a       <= bus.req0_a;
            m_b       <= bus.req0_b;
            m_cin     <= bus.req0_cin;
            m_en_left <= run_len(bus.req0_a ^ bus.req0_b) / 4 + 1;
            m_sum     <= 17'(bus.req0_a) + 17'(bus.req0_b) + 17'(bus.req0_cin);
        end else if (pick() == 1) begin
            m_id      <= 1'b1;
            m_a       <= bus.req1_a;
            m_b       <= bus.req1_b;
            m_cin     <= bus.req1_cin;
            m_en_left <= run_len(bus.req1_a ^ bus.req1_b) / 4 + 1;
            m_sum     <= 17'(bus.req1_a) + 17'(bus.req1_b) + 17'(bus.req1_cin);
        end
    end

    always @(negedge clk) begin
        chk("req0_ready", bus.req0_ready, !rst && m_idle() && pick() == 0);
        chk("req1_ready", bus.req1_ready, !rst && m_idle() && pick() == 1);
        chk("adder_en",   bus.adder_en,   m_en_left != 0);
        chk("adder_a",    bus.adder_a,    m_a);
        chk("adder_b",    bus.adder_b,    m_b);
        chk("adder_cin",  bus.adder_cin,  m_cin);
        chk("rsp_valid",  bus.rsp_valid,  m_rsp);
        chk("rsp_id",     bus.rsp_id,     m_id);
        chk("rsp_sum",    bus.rsp_sum,    m_sum_out);
`ifdef DRCA_ARB_PERF_EN
        chk("perf_ops",   bus.perf_ops,   m_ops);
        chk("perf_busy",  bus.perf_busy,  m_busy);
`else
        chk("perf_ops",   bus.perf_ops,   32'h0);
        chk("perf_busy",  bus.perf_busy,  32'h0);
`endif
    end

    task automatic drop_valids();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_adder_en",  bus.adder_en,  1'b0);
        chk("rst_rsp_sum",   bus.rsp_sum,   17'h0);
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    // Issue one request and measure handshake-to-response latency and enable width
    task automatic do_op(input int id, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic [16:0] exp_sum, input int exp_w,
                         input string nm);
        bit seen;
        int en_cnt;
        int lat;
        @(posedge clk);
        #1;
        if (id == 0) begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_cin = cin;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_cin = cin;
        end
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if ((id == 0 && bus.req0_ready) || (id == 1 && bus.req1_ready)) seen = 1'b1;
        end
        chk({nm, "_accept"}, seen, 1'b1);
        @(posedge clk);
        #1 drop_valids();
        en_cnt = 0;
        lat    = 0;
        seen   = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (bus.adder_en) en_cnt++;
            if (bus.rsp_valid) seen = 1'b1;
        end
        chk({nm, "_latency"}, lat, exp_w + 1);
        chk({nm, "_en_cycles"}, en_cnt, exp_w);
        chk({nm, "_sum"}, bus.rsp_sum, exp_sum);
        chk({nm, "_id"}, bus.rsp_id, id);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16:0] held_sum;
        logic        held_id;
        bit          seen;

        drop_valids();
        bus.req0_a = '0; bus.req0_b = '0; bus.req0_cin = 1'b0;
        bus.req1_a = '0; bus.req1_b = '0; bus.req1_cin = 1'b0;
        bus.rsp_ready = 1'b1;
        #1;
        chk("reset_ready0", bus.req0_ready, 1'b0);
        chk("reset_sum",    bus.rsp_sum,    17'h0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        do_op(0, 16'h0000, 16'h0001, 1'b0, 17'h00001, 1, "minlat");
        do_op(1, 16'hFFFF, 16'h0000, 1'b1, 17'h10000, 5, "fullchain");

        // Arbitration from reset with both held valid
        do_reset();
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b1; bus.req0_a = 16'h00FF; bus.req0_b = 16'h0F00; bus.req0_cin = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_a = 16'h00FF; bus.req1_b = 16'h0F00; bus.req1_cin = 1'b0;
        for (int k = 0; k < 4; k++) begin
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (bus.rsp_valid) seen = 1'b1;
            end
            chk("arb_rsp_seen", seen, 1'b1);
            chk("arb_order", bus.rsp_id, k[0]);
            chk("arb_sum", bus.rsp_sum, 17'h00FFF);
            @(posedge clk);
        end
        #1 drop_valids();

        // Response backpressure: three stalled cycles, handshake on the fourth
        bus.rsp_ready = 1'b0;
        do_op(0, 16'h1234, 16'h0101, 1'b1, 17'h01336, 1, "bp");
        held_sum = bus.rsp_sum;
        held_id  = bus.rsp_id;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            bus.req0_valid = 1'b1;
            bus.req1_valid = 1'b1;
            @(negedge clk);
            chk("bp_valid", bus.rsp_valid, 1'b1);
            chk("bp_sum_stable", bus.rsp_sum, held_sum);
            chk("bp_id_stable", bus.rsp_id, held_id);
            chk("bp_ready0", bus.req0_ready, 1'b0);
            chk("bp_ready1", bus.req1_ready, 1'b0);
            chk("bp_en", bus.adder_en, 1'b0);
        end
        @(posedge clk);
        #1;
        drop_valids();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_valid_4th", bus.rsp_valid, 1'b1);
        @(negedge clk);
        chk("bp_done", bus.rsp_valid, 1'b0);

        // Reset in the second WAIT cycle of a W=5 operation, with rr pointing at 1
        do_op(0, 16'h0000, 16'h0001, 1'b0, 17'h00001, 1, "pre_rst");
        @(posedge clk);
        #1;
        bus.req1_valid = 1'b1; bus.req1_a = 16'hFFFF; bus.req1_b = 16'h0000; bus.req1_cin = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.req1_ready) seen = 1'b1;
        end
        chk("midrst_accept", seen, 1'b1);
        @(posedge clk);
        #1 drop_valids();
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("midrst_en",     bus.adder_en,   1'b0);
        chk("midrst_a",      bus.adder_a,    16'h0);
        chk("midrst_cin",    bus.adder_cin,  1'b0);
        chk("midrst_ready0", bus.req0_ready, 1'b0);
        chk("midrst_ready1", bus.req1_ready, 1'b0);
        @(posedge clk);
        #1 drop_valids();
        #1 rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("midrst_no_rsp", bus.rsp_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        chk("midrst_prio0", bus.req0_ready, 1'b1);
        chk("midrst_prio1", bus.req1_ready, 1'b0);
        @(posedge clk);
        #1 drop_valids();
        repeat (8) @(posedge clk);

        // Performance counters over W=1,5,4
        do_reset();
        do_op(0, 16'h0000, 16'h0001, 1'b0, 17'h00001, 1, "perf1");
        do_op(1, 16'hFFFF, 16'h0000, 1'b1, 17'h10000, 5, "perf2");
        do_op(0, 16'h00FF, 16'h0F00, 1'b0, 17'h00FFF, 4, "perf3");
        @(posedge clk);
        @(negedge clk);
`ifdef DRCA_ARB_PERF_EN
        chk("perf_ops_total",  bus.perf_ops,  32'd3);
        chk("perf_busy_total", bus.perf_busy, 32'd13);
`else
        chk("perf_ops_off",    bus.perf_ops,  32'd0);
        chk("perf_busy_off",   bus.perf_busy, 32'd0);
`endif
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/drca_arbiter.md
# drca_arbiter

Two-requester round-robin arbiter and sequencer for one shared N-bit dynamic ripple-carry adder (DRCA). Accepts operand triples over valid/ready handshakes and drives the adder. Waits a data-dependent number of cycles, derived from the longest carry-propagate run of the operands, then returns the captured sum with the requester ID. Sits between the operand sources and the DRCA instance.

## Interface
- `N`, 16, operand width; must match the attached DRCA.
- `GD_PER_CYC`, 4, carry-chain gate delays that settle per clock period; must be ≥1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0_valid` in 1: requester 0 has an operation.
- `req0_ready` out 1: requester 0 handshake accepted.
- `req0_a`, `req0_b` in N: requester 0 operands.
- `req0_cin` in 1: requester 0 carry-in.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_cin`: same as requester 0, for requester 1.
- `adder_en` out 1: drives DRCA `enable`.
- `adder_a`, `adder_b` out N: drive DRCA operands.
- `adder_cin` out 1: drives DRCA carry-in.
- `adder_s` in N: DRCA sum.
- `adder_cout` in 1: DRCA carry-out.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer accepts result.
- `rsp_id` out 1: index of the served requester.
- `rsp_sum` out N+1: captured {cout, sum}.
- `perf_ops` out 32: completed-operation count.
- `perf_busy` out 32: cycles spent outside IDLE.

## Operation
- States: IDLE, WAIT, RESP.
- **IDLE**
  - If any `reqX_valid`, grant one requester. Priority goes to pointer `rr`; the other requester is granted only if the `rr` requester is not valid.
  - Only the granted `reqX_ready` is asserted, combinationally. All `ready` are 0 outside IDLE.
  - On handshake, latch a, b, cin into the `adder_*` registers and latch the ID.
  - Compute P = a ^ b from the request inputs. L = longest run of consecutive 1s in P (0..N).
  - W = floor(L / GD_PER_CYC) + 1. Load the counter with W and go to WAIT.
- **WAIT**
  - `adder_en` = 1 and the operands are held stable.
  - The counter decrements each cycle.
  - On the edge where counter == 1: capture {`adder_cout`, `adder_s`} into `rsp_sum`, go to RESP.
- **RESP**
  - `rsp_valid` = 1; `rsp_id` and `rsp_sum` are held stable until `rsp_ready`.
  - On handshake: set `rr` = 1 − served ID, go to IDLE, and increment `perf_ops` (feature on).
- `adder_en` = 0 in IDLE and RESP. `adder_a`/`b`/`cin` keep their last values (no toggling).
- No request is accepted while in WAIT or RESP; one operation is outstanding at most.
- Counter width is clog2(N/GD_PER_CYC+2). Maximum W = floor(N/GD_PER_CYC)+1.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE, `rr` = 0, counter = 0.
  - `adder_*` = 0, `rsp_valid` = 0, `rsp_id` = 0, `rsp_sum` = 0, `perf_*` = 0.
  - All `ready` = 0 while `rst` is high.
- Request handshake at edge t → WAIT during cycles t+1..t+W → `rsp_valid` = 1 from cycle t+W+1.
- Response handshake at edge u → IDLE at u+1. The next request can be accepted at edge u+1, so there is one idle cycle between operations.
- Simultaneous valids after reset: requester 0 first. Then requester 1 if it is still valid, regardless of requester 0's next valid.
- Reset during WAIT or RESP discards the operation. No response is produced.
- `rsp_ready` high while `rsp_valid` is low is ignored.

## Configuration
- `DRCA_ARB_PERF_EN`
  - Defined: `perf_ops` counts response handshakes. `perf_busy` counts cycles in WAIT or RESP. Both are 32-bit and wrap at 2^32−1 → 0.
  - Undefined: both outputs are tied to 0 and no counter flops exist. All other behaviour is identical.

## Test plan
N=16, GD_PER_CYC=4, DRCA model attached, `rsp_ready` = 1 unless stated.
- **Minimum latency:** req0 a=0x0000, b=0x0001, cin=0 → L=1, W=1. `rsp_valid` two cycles after the handshake, `rsp_sum` = 0x00001, `rsp_id` = 0.
- **Full chain:** req1 a=0xFFFF, b=0x0000, cin=1 → L=16, W=5. `adder_en` high for exactly 5 cycles, `rsp_sum` = 0x10000, `rsp_id` = 1.
- **Arbitration:** both valid from reset with a=0x00FF, b=0x0F00 → req0 served first (L=12, W=4, sum 0x00FFF), then req1. With both held valid, service alternates 0, 1, 0, 1.
- **Response backpressure:** `rsp_ready` = 0 for 3 cycles in RESP → `rsp_sum`/`rsp_id` stable, both `ready` = 0, `adder_en` = 0. Handshake completes on the 4th cycle.
- **Reset mid-WAIT:** assert `rst` in cycle 2 of a W=5 operation → all outputs 0 immediately. After release there is no `rsp_valid`, and requester 0 has priority.
- **Perf counters:** with `DRCA_ARB_PERF_EN`, three operations with W=1, 5, 4 and immediate `rsp_ready` → `perf_ops` = 3, `perf_busy` = 13. Without the macro, both read 0.
